// File: rtl/nmea_frame_ctrl_if.sv
// Signal bundle linking the NMEA frame controller to the UART receiver,
// the sentence buffer RAM and the frame consumer.
interface nmea_frame_ctrl_if #(
  parameter int N_BITS    = 8,
  parameter int WORD_SIZE = 82,
  parameter int ADDR_W    = $clog2(WORD_SIZE)
);
  logic [N_BITS-1:0] uart_rx_tdata;
  logic              uart_rx_tvalid;
  logic              uart_rx_tready;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [N_BITS-1:0] buf_wr_data;
  logic              frame_tvalid;
  logic              frame_tready;
  logic [ADDR_W:0]   frame_len;
  logic              frame_cks_ok;
  logic              err_format;
  logic              err_overflow;

  // Controller side
  modport master (
    input  uart_rx_tdata, uart_rx_tvalid, frame_tready,
    output uart_rx_tready, buf_wr_en, buf_wr_addr, buf_wr_data,
           frame_tvalid, frame_len, frame_cks_ok, err_format, err_overflow
  );

  // Environment side: UART receiver, buffer RAM and frame consumer
  modport slave (
    output uart_rx_tdata, uart_rx_tvalid, frame_tready,
    input  uart_rx_tready, buf_wr_en, buf_wr_addr, buf_wr_data,
           frame_tvalid, frame_len, frame_cks_ok, err_format, err_overflow
  );
endinterface

// File: rtl/nmea_frame_ctrl.sv
// NMEA sentence framer: hunts for '$', writes accepted bytes into the sentence
// buffer, checks the "*hh\r\n" trailer and hands the frame over with valid/ready.
module nmea_frame_ctrl #(
  parameter int N_BITS    = 8,
  parameter int WORD_SIZE = 82,
  parameter int ADDR_W    = $clog2(WORD_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  nmea_frame_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    BODY   = 3'd1,
    CKS_HI = 3'd2,
    CKS_LO = 3'd3,
    EXP_CR = 3'd4,
    EXP_LF = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [N_BITS-1:0] CH_DOLLAR = N_BITS'(8'h24);
  localparam logic [N_BITS-1:0] CH_STAR   = N_BITS'(8'h2A);
  localparam logic [N_BITS-1:0] CH_CR     = N_BITS'(8'h0D);
  localparam logic [N_BITS-1:0] CH_LF     = N_BITS'(8'h0A);
  localparam logic [ADDR_W:0]   MAX_IDX   = (ADDR_W+1)'(WORD_SIZE);
  localparam logic [ADDR_W:0]   ONE_IDX   = (ADDR_W+1)'(1);

  // Returns {is_hex, nibble}; accepts 0-9, A-F and a-f.
  function automatic logic [4:0] hex_decode(input logic [N_BITS-1:0] ch);
    logic [4:0] res;
    res = 5'd0;
    if ((ch >= N_BITS'(8'h30)) && (ch <= N_BITS'(8'h39))) begin
      res = {1'b1, 4'(ch - N_BITS'(8'h30))};
    end else if ((ch >= N_BITS'(8'h41)) && (ch <= N_BITS'(8'h46))) begin
      res = {1'b1, 4'(ch - N_BITS'(8'h37))};
    end else if ((ch >= N_BITS'(8'h61)) && (ch <= N_BITS'(8'h66))) begin
      res = {1'b1, 4'(ch - N_BITS'(8'h57))};
    end else begin
      res = 5'd0;
    end
    return res;
  endfunction

  state_t            state_r, state_s;
  logic [ADDR_W:0]   index_r, index_s;
  logic [N_BITS-1:0] cks_r, cks_s;
  logic [N_BITS-1:0] rx_cks_r, rx_cks_s;
  logic              tready_r;
  logic              wr_en_r, wr_en_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic [N_BITS-1:0] wr_data_r, wr_data_s;
  logic              fmt_r, fmt_s;
  logic              ovf_r, ovf_s;
  logic              frame_tvalid_r, tvalid_s;
  logic [ADDR_W:0]   frame_len_r;
  logic              frame_cks_ok_r;
  logic              accept_s;
  logic              wr_ok_s;
  logic [4:0]        hex_s;
  logic [N_BITS-1:0] byte_s;

  // Next-state, buffer write and checksum decisions for the accepted byte
  always_comb begin
    byte_s    = bus.uart_rx_tdata;
    accept_s  = bus.uart_rx_tvalid && tready_r;
    hex_s     = hex_decode(byte_s);
    state_s   = state_r;
    index_s   = index_r;
    cks_s     = cks_r;
    rx_cks_s  = rx_cks_r;
    wr_ok_s   = 1'b0;
    wr_en_s   = 1'b0;
    wr_addr_s = {ADDR_W{1'b0}};
    wr_data_s = byte_s;
    fmt_s     = 1'b0;
    ovf_s     = 1'b0;
    tvalid_s  = (state_r == DONE) && !(frame_tvalid_r && bus.frame_tready);

    if (accept_s) begin
      if (byte_s == CH_DOLLAR) begin
        // '$' always (re)starts a sentence; DONE never accepts so it cannot land here
        wr_en_s   = 1'b1;
        wr_addr_s = {ADDR_W{1'b0}};
        index_s   = ONE_IDX;
        cks_s     = {N_BITS{1'b0}};
        state_s   = BODY;
      end else begin
        case (state_r)
          BODY:           wr_ok_s = (byte_s != CH_CR) && (byte_s != CH_LF);
          CKS_HI, CKS_LO: wr_ok_s = hex_s[4];
          EXP_CR:         wr_ok_s = (byte_s == CH_CR);
          EXP_LF:         wr_ok_s = (byte_s == CH_LF);
          default:        wr_ok_s = 1'b0;
        endcase

        if ((state_r == HUNT) || (state_r == DONE)) begin
          state_s = state_r;
        end else if (!wr_ok_s) begin
          fmt_s   = 1'b1;
          state_s = HUNT;
        end else if (index_r == MAX_IDX) begin
          ovf_s   = 1'b1;
          state_s = HUNT;
        end else begin
          wr_en_s   = 1'b1;
          wr_addr_s = index_r[ADDR_W-1:0];
          index_s   = index_r + ONE_IDX;
          case (state_r)
            BODY: begin
              if (byte_s == CH_STAR) begin
                state_s = CKS_HI;
              end else begin
                cks_s = cks_r ^ byte_s;
              end
            end
            CKS_HI: begin
              rx_cks_s = N_BITS'({hex_s[3:0], rx_cks_r[3:0]});
              state_s  = CKS_LO;
            end
            CKS_LO: begin
              rx_cks_s = N_BITS'({rx_cks_r[7:4], hex_s[3:0]});
              state_s  = EXP_CR;
            end
            EXP_CR:  state_s = EXP_LF;
            EXP_LF:  state_s = DONE;
            default: state_s = state_r;
          endcase
        end
      end
    end else if ((state_r == DONE) && frame_tvalid_r && bus.frame_tready) begin
      state_s = HUNT;
    end else begin
      state_s = state_r;
    end
  end

  // FSM state, write index and checksum registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= HUNT;
      index_r  <= {(ADDR_W+1){1'b0}};
      cks_r    <= {N_BITS{1'b0}};
      rx_cks_r <= {N_BITS{1'b0}};
    end else begin
      state_r  <= state_s;
      index_r  <= index_s;
      cks_r    <= cks_s;
      rx_cks_r <= rx_cks_s;
    end
  end

  // Registered outputs: write strobe, error pulses and the frame descriptor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tready_r       <= 1'b1;
      wr_en_r        <= 1'b0;
      wr_addr_r      <= {ADDR_W{1'b0}};
      wr_data_r      <= {N_BITS{1'b0}};
      fmt_r          <= 1'b0;
      ovf_r          <= 1'b0;
      frame_tvalid_r <= 1'b0;
      frame_len_r    <= {(ADDR_W+1){1'b0}};
      frame_cks_ok_r <= 1'b0;
    end else begin
      tready_r       <= (state_s != DONE);
      wr_en_r        <= wr_en_s;
      wr_addr_r      <= wr_addr_s;
      wr_data_r      <= wr_data_s;
      fmt_r          <= fmt_s;
      ovf_r          <= ovf_s;
      frame_tvalid_r <= tvalid_s;
      frame_len_r    <= tvalid_s ? index_r : {(ADDR_W+1){1'b0}};
      frame_cks_ok_r <= tvalid_s ? (rx_cks_r == cks_r) : 1'b0;
    end
  end

  assign bus.uart_rx_tready = tready_r;
  assign bus.buf_wr_en      = wr_en_r;
  assign bus.buf_wr_addr    = wr_addr_r;
  assign bus.buf_wr_data    = wr_data_r;
  assign bus.frame_tvalid   = frame_tvalid_r;
  assign bus.frame_len      = frame_len_r;
  assign bus.frame_cks_ok   = frame_cks_ok_r;
  assign bus.err_format     = fmt_r;
  assign bus.err_overflow   = ovf_r;

endmodule
